// File: rtl/pipelined_multiplier_l3_if.sv
// Issue / writeback bus of the pipelined multiply execute unit.
// The master side issues operations and consumes results. The slave side is the unit itself.
interface pipelined_multiplier_l3_if #(
    parameter int p_width          = 32,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    // issue side
    logic                        d_val;
    logic                        d_rdy;
    logic [1:0]                  d_op;
    logic [p_width-1:0]          d_op1;
    logic [p_width-1:0]          d_op2;
    logic [p_seq_num_bits-1:0]   d_seq_num;
    logic [p_phys_addr_bits-1:0] d_waddr;
    logic                        d_wen;
    logic [31:0]                 d_pc;

    // writeback side
    logic                        w_val;
    logic                        w_rdy;
    logic [p_width-1:0]          w_wdata;
    logic [p_seq_num_bits-1:0]   w_seq_num;
    logic [p_phys_addr_bits-1:0] w_waddr;
    logic                        w_wen;
    logic [31:0]                 w_pc;

    // control / status
    logic                        squash;
    logic                        busy;

    modport master (
        output d_val, d_op, d_op1, d_op2, d_seq_num, d_waddr, d_wen, d_pc,
        output w_rdy, squash,
        input  d_rdy, w_val, w_wdata, w_seq_num, w_waddr, w_wen, w_pc, busy
    );

    modport slave (
        input  d_val, d_op, d_op1, d_op2, d_seq_num, d_waddr, d_wen, d_pc,
        input  w_rdy, squash,
        output d_rdy, w_val, w_wdata, w_seq_num, w_waddr, w_wen, w_pc, busy
    );
endinterface

// File: rtl/pipelined_multiplier_l3.sv
// Parametrised elastic RV32M multiply pipe (MUL/MULH/MULHSU/MULHU).
// The full product is formed at issue and followed by p_stages registers, so retiming can spread the multiplier across them.
// Each stage stalls on its own, which lets bubbles collapse under writeback backpressure.
// Squash clears every valid bit on the next edge.
module pipelined_multiplier_l3 #(
    parameter int p_width          = 32,
    parameter int p_stages         = 4,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic clk,
    input  logic rst,
    pipelined_multiplier_l3_if.slave bus
);

    typedef enum logic [1:0] {
        op_mul    = 2'd0,
        op_mulh   = 2'd1,
        op_mulhsu = 2'd2,
        op_mulhu  = 2'd3
    } op_e;

    typedef struct packed {
        logic [p_width-1:0]          data;
        logic [p_seq_num_bits-1:0]   seq_num;
        logic [p_phys_addr_bits-1:0] waddr;
        logic                        wen;
        logic [31:0]                 pc;
    } payload_t;

    localparam int last = p_stages - 1;

    logic [p_stages-1:0] valid_q;
    logic [p_stages-1:0] adv;
    payload_t            stage_q [p_stages];

    op_e                 issue_op;
    logic                sx1;
    logic                sx2;
    logic [2*p_width-1:0] ext1;
    logic [2*p_width-1:0] ext2;
    logic [2*p_width-1:0] product;
    payload_t            issue_pl;
    logic                accept_rdy;

    // Operand extension, product and mode-dependent half select for the incoming issue.
    always_comb begin
        // NOTE: every variable gets a value on every path through this block, so no latch can be inferred.
        issue_op = op_e'(bus.d_op);
        sx1      = (issue_op == op_mulh) || (issue_op == op_mulhsu);
        sx2      = (issue_op == op_mulh);
        ext1     = {{p_width{sx1 & bus.d_op1[p_width-1]}}, bus.d_op1};
        ext2     = {{p_width{sx2 & bus.d_op2[p_width-1]}}, bus.d_op2};
        product  = ext1 * ext2;

        issue_pl         = '0;
        issue_pl.data    = (issue_op == op_mul) ? product[p_width-1:0]
                                                : product[2*p_width-1:p_width];
        issue_pl.seq_num = bus.d_seq_num;
        issue_pl.waddr   = bus.d_waddr;
        issue_pl.wen     = bus.d_wen;
        issue_pl.pc      = bus.d_pc;
    end

    // Advance chain from the writeback end back to S0: a stage moves when the one ahead is empty or moving.
    always_comb begin
        logic go;
        adv       = '0;
        go        = bus.w_rdy && !bus.squash;
        adv[last] = go;
        for (int k = last - 1; k >= 0; k--) begin
            go     = !valid_q[k+1] || go;
            adv[k] = go;
        end
    end

    assign accept_rdy    = (!valid_q[0] || adv[0]) && !bus.squash;
    assign bus.d_rdy     = accept_rdy;
    assign bus.w_val     = valid_q[last] && !bus.squash;
    assign bus.w_wdata   = stage_q[last].data;
    assign bus.w_seq_num = stage_q[last].seq_num;
    assign bus.w_waddr   = stage_q[last].waddr;
    assign bus.w_wen     = stage_q[last].wen;
    assign bus.w_pc      = stage_q[last].pc;
    assign bus.busy      = |valid_q;

    // Valid bits: load from upstream on advance, drain when emptied, clear on squash or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (bus.squash) begin
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage see its neighbour's pre-edge value, so the shift order does not matter.
            if (accept_rdy) begin
                valid_q[0] <= bus.d_val;
            end
            for (int k = 1; k < p_stages; k++) begin
                if (adv[k-1]) begin
                    valid_q[k] <= valid_q[k-1];
                end else if (adv[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Payload registers move only alongside a valid op, so a stalled last stage holds steady.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset because the valid bits alone qualify it.
        if (accept_rdy && bus.d_val) begin
            stage_q[0] <= issue_pl;
        end
        for (int k = 1; k < p_stages; k++) begin
            if (adv[k-1] && valid_q[k-1]) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_multiplier_l3.sv
// Directed bench for pipelined_multiplier_l3 with p_width 32 and p_stages 4.
// The bench drives inputs 1 ns after each rising edge and samples outputs 2 ns after it.
module tb_pipelined_multiplier_l3;

    localparam int p_width          = 32;
    localparam int p_stages         = 4;
    localparam int p_seq_num_bits   = 5;
    localparam int p_phys_addr_bits = 6;

    localparam logic [1:0] op_mul    = 2'd0;
    localparam logic [1:0] op_mulh   = 2'd1;
    localparam logic [1:0] op_mulhsu = 2'd2;
    localparam logic [1:0] op_mulhu  = 2'd3;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int n_vec = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs [n_vec];

    pipelined_multiplier_l3_if #(
        .p_width(p_width), .p_seq_num_bits(p_seq_num_bits), .p_phys_addr_bits(p_phys_addr_bits)
    ) bus ();

    pipelined_multiplier_l3 #(
        .p_width(p_width), .p_stages(p_stages),
        .p_seq_num_bits(p_seq_num_bits), .p_phys_addr_bits(p_phys_addr_bits)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] seq);
        bus.d_val     = v;
        bus.d_op      = op;
        bus.d_op1     = a;
        bus.d_op2     = b;
        bus.d_seq_num = seq;
        bus.d_waddr   = 6'(seq + 5'd7);
        bus.d_wen     = seq[0];
        bus.d_pc      = 32'h1000 + {27'd0, seq};
    endtask

    // Issue one op into an idle unit with w_rdy high, then wait (bounded) for its result.
    task automatic run_single(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] seq, input logic [31:0] exp);
        int lat;
        bit found;
        bus.w_rdy = 1'b1;
        drive(1'b1, op, a, b, seq);
        #1;
        check({name, "_d_rdy"}, 64'(bus.d_rdy), 64'd1);
        tick();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        lat = 1;
        found = 0;
        while (lat <= 20 && !found) begin
            #1;
            if (bus.w_val) found = 1;
            else begin
                tick();
                lat++;
            end
        end
        check({name, "_latency"}, found ? 64'(lat) : 64'hFFFF, 64'd4);
        if (found) begin
            check({name, "_wdata"}, 64'(bus.w_wdata), 64'(exp));
            check({name, "_seq"}, 64'(bus.w_seq_num), 64'(seq));
            check({name, "_waddr"}, 64'(bus.w_waddr), 64'(6'(seq + 5'd7)));
            check({name, "_wen"}, 64'(bus.w_wen), 64'(seq[0]));
            check({name, "_pc"}, 64'(bus.w_pc), 64'(32'h1000 + {27'd0, seq}));
        end
        tick();
        #1;
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        tick();
    endtask

    initial begin
        vecs[0]  = '{op_mul,    32'd7,        32'd6,        32'd42};
        vecs[1]  = '{op_mul,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2]  = '{op_mulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{op_mulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4]  = '{op_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[5]  = '{op_mulhu,  32'h80000000, 32'd2,        32'h00000001};
        vecs[6]  = '{op_mulh,   32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        vecs[7]  = '{op_mul,    32'h00010000, 32'h00010000, 32'h00000000};
        vecs[8]  = '{op_mulh,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[9]  = '{op_mulhsu, 32'h80000000, 32'h80000000, 32'hC0000000};
        vecs[10] = '{op_mulhu,  32'h80000000, 32'h80000000, 32'h40000000};
        vecs[11] = '{op_mul,    32'h12345678, 32'h00000010, 32'h23456780};
        vecs[12] = '{op_mulh,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};

        bus.w_rdy  = 1'b1;
        bus.squash = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);

        // reset state
        #3;
        check("reset_w_val", 64'(bus.w_val), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_d_rdy", 64'(bus.d_rdy), 64'd1);
        #20 rst = 1'b1;
        tick();

        // single MUL with latency and metadata pass-through
        run_single("mul_7x6", op_mul, 32'd7, 32'd6, 5'd3, 32'd42);

        // table stream: one op per cycle, results exactly p_stages cycles later, in order
        bus.w_rdy = 1'b1;
        for (int c = 0; c < n_vec + 6; c++) begin
            if (c < n_vec) drive(1'b1, vecs[c].op, vecs[c].a, vecs[c].b, 5'(c));
            else           drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
            #1;
            check($sformatf("stream_w_val_c%0d", c), 64'(bus.w_val), 64'(c >= 4 && c < n_vec + 4));
            if (c >= 4 && c < n_vec + 4 && bus.w_val) begin
                check($sformatf("stream_wdata_v%0d", c - 4), 64'(bus.w_wdata), 64'(vecs[c-4].exp));
                check($sformatf("stream_seq_v%0d", c - 4), 64'(bus.w_seq_num), 64'(5'(c - 4)));
            end
            tick();
        end

        // backpressure: 6 attempted issues, only 4 fit
        bus.w_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, op_mul, 32'(i + 1), 32'd10, 5'(i));
            #1;
            check($sformatf("bp_d_rdy_%0d", i), 64'(bus.d_rdy), 64'(i < 4));
            tick();
        end
        // raise w_rdy while a fifth op is offered: accepted in the same cycle
        bus.w_rdy = 1'b1;
        drive(1'b1, op_mul, 32'd5, 32'd10, 5'd4);
        #1;
        check("bp_release_d_rdy", 64'(bus.d_rdy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #1;
            check($sformatf("bp_drain_w_val_%0d", i), 64'(bus.w_val), 64'd1);
            check($sformatf("bp_drain_wdata_%0d", i), 64'(bus.w_wdata), 64'((i + 1) * 10));
            check($sformatf("bp_drain_seq_%0d", i), 64'(bus.w_seq_num), 64'(i));
            tick();
            drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        end
        #1;
        check("bp_drain_empty", 64'(bus.busy), 64'd0);
        tick();

        // bubble collapse: issues in cycles 0 and 2 with w_rdy low
        bus.w_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(1'b1, op_mul, 32'd3, 32'd5, 5'd10);
            else if (c == 2) drive(1'b1, op_mul, 32'd4, 32'd5, 5'd11);
            else             drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
            #1;
            check($sformatf("bubble_d_rdy_c%0d", c), 64'(bus.d_rdy), 64'd1);
            tick();
        end
        bus.w_rdy = 1'b1;
        #1;
        check("bubble_first_w_val", 64'(bus.w_val), 64'd1);
        check("bubble_first_wdata", 64'(bus.w_wdata), 64'd15);
        tick();
        #1;
        check("bubble_second_w_val", 64'(bus.w_val), 64'd1);
        check("bubble_second_wdata", 64'(bus.w_wdata), 64'd20);
        tick();
        #1;
        check("bubble_done_busy", 64'(bus.busy), 64'd0);
        tick();

        // squash with three ops in flight and a result waiting
        bus.w_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive(1'b1, op_mul, 32'(c + 2), 32'd3, 5'(20 + c));
            else       drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
            tick();
        end
        #1;
        check("squash_pre_w_val", 64'(bus.w_val), 64'd1);
        bus.squash = 1'b1;
        bus.w_rdy  = 1'b1;
        drive(1'b1, op_mul, 32'd9, 32'd9, 5'd30);
        #1;
        check("squash_w_val", 64'(bus.w_val), 64'd0);
        check("squash_d_rdy", 64'(bus.d_rdy), 64'd0);
        tick();
        bus.squash = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("squash_busy_next", 64'(bus.busy), 64'd0);
        check("squash_w_val_next", 64'(bus.w_val), 64'd0);
        tick();
        run_single("post_squash_mulh", op_mulh, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd12, 32'h3FFFFFFF);

        // asynchronous reset between edges with ops in flight
        bus.w_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c < 2) drive(1'b1, op_mul, 32'd11, 32'd11, 5'(c));
            else       drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
            tick();
        end
        #1;
        check("arst_pre_w_val", 64'(bus.w_val), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_w_val", 64'(bus.w_val), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        run_single("post_reset_mulhu", op_mulhu, 32'h80000000, 32'd2, 5'd17, 32'h00000001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipelined_multiplier_l3.md
# pipelined_multiplier_l3

Parametrised next-generation pipelined multiply execute unit for the Blimp out-of-order core. It sits between the decode-issue unit and the writeback-commit unit, occupying one execute pipe. It generalises the fixed 4-stage multiplier: operand width, stage count and full RV32M multiply mode (MUL/MULH/MULHSU/MULHU) are configurable. It adds per-stage elastic stalling, so bubbles collapse under backpressure, and a single-cycle squash that flushes all in-flight work.

## Interface
- p_width, 32: operand and result width in bits
- p_stages, 4: pipeline depth, ≥1; equals unstalled latency
- p_seq_num_bits, 5: sequence number width
- p_phys_addr_bits, 6: physical register address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; one clock
- d_val  in  1  issue request valid
- d_rdy  out  1  unit can accept an issue this cycle
- d_op  in  2  mode: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
- d_op1, d_op2  in  p_width  operands (op1 = rs1, op2 = rs2)
- d_seq_num  in  p_seq_num_bits  instruction tag
- d_waddr  in  p_phys_addr_bits  destination physical register
- d_wen  in  1  instruction writes a register
- d_pc  in  32  instruction PC
- w_val  out  1  result valid to writeback
- w_rdy  in  1  writeback accepts the result
- w_wdata  out  p_width  result
- w_seq_num, w_waddr, w_wen, w_pc  out  as d_*  metadata passed through unchanged
- squash  in  1  flush all in-flight operations
- busy  out  1  at least one stage holds a valid operation

## Operation
- Stage registers S0..S(p_stages-1) each hold a valid bit plus payload: partial or final product, op, and metadata.
- Issue transfer occurs when d_val && d_rdy. The operation is written into S0.
- Stage k advances when S(k+1) is empty or is itself advancing. The last stage advances when w_rdy.
- d_rdy = !valid[S0] || S0 advances, and is 0 when squash is high.
- w_val = valid[last] && !squash. w_* payload fields come from the last stage. Payload must hold stable while w_val && !w_rdy.
- Arithmetic uses a 2*p_width product:
  - op1 is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - op2 is sign-extended for MULH only.
  - MUL returns product[p_width-1:0]. All other modes return product[2p_width-1:p_width].
- Partial-product placement across stages is implementation-defined. Only the output is checked.
- Squash:
  - While squash is high, w_val and d_rdy are forced to 0 in that same cycle.
  - On the next edge, all valid bits clear. No issue or writeback transfer occurs in that cycle.
- busy = OR of all stage valid bits.
- Operations never reorder. Capacity is p_stages operations.

## Timing
- Reset (rst low, asynchronous): all valid bits = 0, so w_val = 0 and busy = 0. d_rdy = 1 once squash is low. Payload registers need not be reset.
- Latency: an issue accepted at edge t is presented with w_val = 1 in the cycle after edge t+p_stages-1. In other words, p_stages cycles, with no stalls.
- Throughput: 1 op/cycle while w_rdy stays high.
- Full: all stages valid and w_rdy = 0 gives d_rdy = 0. When w_rdy rises, d_rdy = 1 in the same cycle, with no bubble.
- Bubbles: an empty stage accepts from upstream even while the stage ahead is stalled.
- Asserting rst mid-operation drops all in-flight ops immediately. There is no partial output.
- Squash and w_rdy high in the same cycle: the last op is not transferred; it is flushed.
- p_stages = 1: the unit degenerates to a single elastic register with the same rules.

## Test plan
- Reset then single MUL, op1 = 7, op2 = 6, seq = 3 -> w_val rises 4 cycles after issue (p_stages = 4), w_wdata = 42, w_seq_num = 3, busy = 0 afterward.
- Mode sweep, op1 = 0xFFFFFFFF, op2 = 0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
  - MULHU -> 0xFFFFFFFE
- Backpressure: 6 back-to-back issues with w_rdy = 0 -> exactly 4 accepted, then d_rdy = 0. Raise w_rdy -> results drain in issue order, one per cycle, and d_rdy = 1 in that same cycle.
- Bubble collapse: issue on cycles 0 and 2 with w_rdy held 0 -> both ops occupy the last two stages and d_rdy stays 1.
- Squash with 3 ops in flight and w_val = 1 -> w_val = 0 that cycle and busy = 0 next cycle. A new issue afterward completes normally with the correct value.
- Asynchronous reset asserted mid-stream between edges -> w_val and busy drop immediately. After release, a MULHU of 0x80000000 × 2 returns 1.
